// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for ram_port_arbiter: video read stream plus queued write stream.
// master = requester (game/PS2/video logic), slave = arbiter.
interface ram_port_arbiter_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8,
   parameter int WQ_DEPTH      = 4
);
   localparam int CW = $clog2(WQ_DEPTH) + 1;

   logic                     rd_req;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     rd_valid;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic                     rd_miss;
   logic                     wr_valid;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     wr_ready;
   logic [CW-1:0]            wq_count;
   logic                     wr_overflow;

   modport master (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
      input  rd_valid, rd_data, rd_miss, wr_ready, wq_count, wr_overflow
   );

   modport slave (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
      output rd_valid, rd_data, rd_miss, wr_ready, wq_count, wr_overflow
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM front end: reads always win, writes queue and drain on idle cycles.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8,
   parameter int WQ_DEPTH      = 4,
   parameter int STARVE_LIMIT  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   ram_port_arbiter_if.slave        bus,
   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_dataIn,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut
);
   localparam int PW = $clog2(WQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(WQ_DEPTH);

   typedef enum logic [1:0] {IDLE, SERVE_READ, DRAIN} grant_t;

   grant_t                   grant;
   logic [ADDRESS_WIDTH-1:0] wq_addr [WQ_DEPTH];
   logic [DATA_WIDTH-1:0]    wq_data [WQ_DEPTH];
   logic [PW-1:0]            wptr, rptr;
   logic [CW-1:0]            count;
   logic                     q_empty, push, pop, forced;
   logic                     rd_v1, rd_v2, miss1, miss2, overflow;
   logic [DATA_WIDTH-1:0]    rd_data_q;

   assign q_empty = (count == '0);
   assign push    = bus.wr_valid && bus.wr_ready;
   assign pop     = (grant == DRAIN);

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
   logic [SW-1:0] starve;

   assign forced = bus.rd_req && !q_empty && (starve == SLIM);

   always_ff @(posedge clk) begin
      if (!reset_n)
         starve <= '0;
      else if (grant == DRAIN || q_empty)
         starve <= '0;
      else if (grant == SERVE_READ)
         starve <= starve + 1'b1;
   end
`else
   assign forced = 1'b0;
`endif

   // Grant is gated by reset so a queue being flushed never reaches the RAM.
   always_comb begin
      grant = IDLE;
      if (!reset_n)
         grant = IDLE;
      else if (bus.rd_req && !forced)
         grant = SERVE_READ;
      else if (!q_empty)
         grant = DRAIN;
   end

   always_comb begin
      ram_wEn    = 1'b0;
      ram_addr   = '0;
      ram_dataIn = '0;
      case (grant)
         SERVE_READ: ram_addr = bus.rd_addr;
         DRAIN: begin
            ram_wEn    = 1'b1;
            ram_addr   = wq_addr[rptr];
            ram_dataIn = wq_data[rptr];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         wq_addr[wptr] <= bus.wr_addr;
         wq_data[wptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.wr_valid && !bus.wr_ready) overflow <= 1'b1;
      end
   end

   // Stage 1 marks RAM output valid next cycle; stage 2 is the re-timed user valid.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_v1     <= 1'b0;
         rd_v2     <= 1'b0;
         miss1     <= 1'b0;
         miss2     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_v1 <= (grant == SERVE_READ);
         rd_v2 <= rd_v1;
         miss1 <= forced;
         miss2 <= miss1;
         if (rd_v1) rd_data_q <= ram_dataOut;
      end
   end

   assign bus.wr_ready    = (count < FULL);
   assign bus.wq_count    = count;
   assign bus.wr_overflow = overflow;
   assign bus.rd_valid    = rd_v2;
   assign bus.rd_miss     = miss2;
   assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: table vectors, hand sequences, read/write scoreboards.
// Expectations for the forced-write case follow ARB_STARVE_GUARD_EN.
module tb_ram_port_arbiter;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       ram_wEn;
   logic [7:0] ram_addr, ram_dataIn;
   logic [7:0] ram_dout = '0;

   ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .WQ_DEPTH(4)) bus ();

   ram_port_arbiter #(
      .DATA_WIDTH(8), .ADDRESS_WIDTH(8), .WQ_DEPTH(4), .STARVE_LIMIT(16)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dout)
   );

   always #5 clk = ~clk;

   typedef struct { logic miss; logic [7:0] data; int due; } rd_e_t;
   typedef struct { logic [7:0] addr; logic [7:0] data; } wr_e_t;
   typedef struct {
      logic rr; logic [7:0] ra; logic wv; logic [7:0] wa; logic [7:0] wd;
      int exp_cnt; logic exp_wen; logic exp_rdy;
   } vec_t;

   rd_e_t rd_exp[$];
   wr_e_t wq_exp[$];
   logic [7:0] ram [256];
   logic [7:0] shadow [256];
   bit   ram_ready = 0, sh_ready = 0, mon_en = 0;
   int   n_checks = 0, n_fail = 0, cyc = 0, mcount = 0;
   logic ovf = 0;
   logic [7:0] held = '0;

   // RAM device: registered read, one-cycle latency
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
         ram_ready = 1;
      end else begin
         if (ram_wEn) ram[ram_addr] <= ram_dataIn;
         ram_dout <= ram[ram_addr];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      rd_e_t r;
      wr_e_t w;
      if (!sh_ready) begin
         for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
         sh_ready = 1;
      end
      if (mon_en) begin
         if (ram_wEn) begin
            if (wq_exp.size() == 0) fail_now("spurious_ram_write");
            else begin
               w = wq_exp.pop_front();
               chk("wr_addr_order", ram_addr, w.addr);
               chk("wr_data_order", ram_dataIn, w.data);
               shadow[w.addr] = w.data;
            end
         end
         if (bus.rd_valid || bus.rd_miss) begin
            if (rd_exp.size() == 0) fail_now("spurious_rd_valid_or_miss");
            else begin
               r = rd_exp.pop_front();
               chk("rd_latency", cyc, r.due);
               chk("rd_miss", bus.rd_miss, r.miss);
               chk("rd_valid", bus.rd_valid, !r.miss);
               if (!r.miss) begin
                  chk("rd_data", bus.rd_data, r.data);
                  held = r.data;
               end
            end
         end else if (rd_exp.size() > 0 && rd_exp[0].due <= cyc) begin
            fail_now("rd_timeout");
            void'(rd_exp.pop_front());
         end
         if (!bus.rd_valid) chk("rd_data_hold", bus.rd_data, held);
      end
   end

   task automatic cycle(input logic rr, input logic [7:0] ra, input logic wv, input logic [7:0] wa,
                        input logic [7:0] wd, input logic forced,
                        output int s_cnt, output logic s_wen, output logic s_rdy);
      logic acc, exp_wen;
      bus.rd_req = rr; bus.rd_addr = ra; bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
      acc     = wv && (mcount < 4);
      exp_wen = (!rr || forced) && (mcount != 0);
      if (rr)  rd_exp.push_back('{miss: forced, data: shadow[ra], due: cyc + 2});
      if (acc) wq_exp.push_back('{addr: wa, data: wd});
      @(negedge clk);
      s_cnt = int'(bus.wq_count); s_wen = ram_wEn; s_rdy = bus.wr_ready;
      chk("wq_count", bus.wq_count, mcount);
      chk("wr_ready", bus.wr_ready, mcount < 4);
      chk("wr_overflow", bus.wr_overflow, ovf);
      chk("ram_wEn", ram_wEn, exp_wen);
      if (rr && !forced) chk("ram_addr_read", ram_addr, ra);
      if (!rr && mcount == 0) chk("ram_addr_idle", {ram_addr, ram_dataIn}, 0);
      @(posedge clk); #1;
      mcount = mcount + int'(acc) - int'(exp_wen);
      if (wv && !acc) ovf = 1'b1;
   endtask

   task automatic step(input logic rr, input logic [7:0] ra, input logic wv, input logic [7:0] wa,
                       input logic [7:0] wd, input logic forced);
      int c; logic w, r;
      cycle(rr, ra, wv, wa, wd, forced, c, w, r);
   endtask

   task automatic do_reset(input logic rr, input logic wv);
      mon_en = 0; reset_n = 1'b0;
      bus.rd_req = rr; bus.rd_addr = 8'h55; bus.wr_valid = wv; bus.wr_addr = 8'h66; bus.wr_data = 8'h77;
      rd_exp.delete(); wq_exp.delete();
      mcount = 0; ovf = 1'b0; held = '0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_miss", bus.rd_miss, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_wq_count", bus.wq_count, 0);
      chk("rst_wr_ready", bus.wr_ready, 1);
      chk("rst_wr_overflow", bus.wr_overflow, 0);
      chk("rst_ram_wEn", ram_wEn, 0);
      @(posedge clk); #1;
      reset_n = 1'b1; mon_en = 1;
      bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [19];
      int   c;
      logic w, r;
      vt[0]  = '{1'b1, 8'h20, 1'b1, 8'h01, 8'h11, 0, 1'b0, 1'b1};
      vt[1]  = '{1'b1, 8'h21, 1'b1, 8'h02, 8'h22, 1, 1'b0, 1'b1};
      vt[2]  = '{1'b1, 8'h22, 1'b1, 8'h03, 8'h33, 2, 1'b0, 1'b1};
      vt[3]  = '{1'b1, 8'h23, 1'b0, 8'h00, 8'h00, 3, 1'b0, 1'b1};
      vt[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3, 1'b1, 1'b1};
      vt[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 2, 1'b1, 1'b1};
      vt[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1, 1'b1, 1'b1};
      vt[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 8'h28, 1'b1, 8'h04, 8'h44, 0, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 8'h29, 1'b1, 8'h05, 8'h55, 1, 1'b0, 1'b1};
      vt[10] = '{1'b1, 8'h2A, 1'b1, 8'h06, 8'h66, 2, 1'b0, 1'b1};
      vt[11] = '{1'b1, 8'h2B, 1'b1, 8'h07, 8'h77, 3, 1'b0, 1'b1};
      vt[12] = '{1'b1, 8'h2C, 1'b1, 8'h08, 8'h88, 4, 1'b0, 1'b0};
      vt[13] = '{1'b1, 8'h2D, 1'b0, 8'h00, 8'h00, 4, 1'b0, 1'b0};
      vt[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 4, 1'b1, 1'b0};
      vt[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3, 1'b1, 1'b1};
      vt[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 2, 1'b1, 1'b1};
      vt[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1, 1'b1, 1'b1};
      vt[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1};

      reset_n = 1'b0;
      bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

      // Reset held with both requests active must not queue anything
      do_reset(1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Single write then read-back with fixed two-cycle latency
      step(1'b0, 8'h00, 1'b1, 8'h10, 8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Queued writes under reads, ordered drain, then overflow
      for (int i = 0; i < 19; i++) begin
         cycle(vt[i].rr, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].wd, 1'b0, c, w, r);
         chk($sformatf("vec%0d_cnt", i), c, vt[i].exp_cnt);
         chk($sformatf("vec%0d_wen", i), w, vt[i].exp_wen);
         chk($sformatf("vec%0d_rdy", i), r, vt[i].exp_rdy);
      end
      step(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Starvation: one queued write against continuous reads
      step(1'b1, 8'h30, 1'b1, 8'h40, 8'hC3, 1'b0);
      for (int i = 1; i <= 16; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef ARB_STARVE_GUARD_EN
      step(1'b1, 8'h50, 1'b0, 8'h00, 8'h00, 1'b1);
`else
      step(1'b1, 8'h50, 1'b0, 8'h00, 8'h00, 1'b0);
`endif
      repeat (3) step(1'b1, 8'h51, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (4) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Reset with queued writes and reads in flight discards all of it
      step(1'b1, 8'h60, 1'b1, 8'h70, 8'h01, 1'b0);
      step(1'b1, 8'h61, 1'b1, 8'h71, 8'h02, 1'b0);
      step(1'b1, 8'h62, 1'b1, 8'h72, 8'h03, 1'b0);
      do_reset(1'b0, 1'b0);
      repeat (6) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 8'h70, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      chk("rd_scoreboard_drained", rd_exp.size(), 0);
      chk("wr_scoreboard_drained", wq_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
